// File: rtl/verify_input_sequencer_pkg.sv
// Shared types and constants for the verify load/unload input sequencer.
// Covers the field tags, FSM state codes, per-security-level sizes and field ordering.
package verify_input_sequencer_pkg;

    typedef enum logic [2:0] {
        F_RHO  = 3'd0,
        F_C    = 3'd1,
        F_Z    = 3'd2,
        F_T1   = 3'd3,
        F_MLEN = 3'd4,
        F_MSG  = 3'd5,
        F_H    = 3'd6
    } field_t;

    localparam logic [1:0] VERIFY_MODE = 2'd2;

    localparam int SEED_WORDS_ALL = 4;
    localparam int Z_WORDS_L2     = 288;
    localparam int Z_WORDS_L3     = 400;
    localparam int Z_WORDS_L5     = 560;
    localparam int T1_WORDS_L2    = 160;
    localparam int T1_WORDS_L3    = 240;
    localparam int T1_WORDS_L5    = 320;
    localparam int H_WORDS_L2     = 11;
    localparam int H_WORDS_L3     = 8;
    localparam int H_WORDS_L5     = 11;

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t S_IDLE     = 4'd0;
    localparam seq_state_t S_L_RHO    = 4'd1;
    localparam seq_state_t S_L_C      = 4'd2;
    localparam seq_state_t S_L_Z      = 4'd3;
    localparam seq_state_t S_L_T1     = 4'd4;
    localparam seq_state_t S_L_MLEN   = 4'd5;
    localparam seq_state_t S_L_MSG    = 4'd6;
    localparam seq_state_t S_L_H      = 4'd7;
    localparam seq_state_t S_WAIT_RES = 4'd8;
    localparam seq_state_t S_UNLOAD   = 4'd9;

    // Load state that follows s; S_WAIT_RES marks the end of the field list.
    function automatic seq_state_t next_load_state(input seq_state_t s, input logic high_perf);
        seq_state_t n;
        n = S_IDLE;
        if (high_perf) begin
            case (s)
                S_L_RHO:  n = S_L_C;
                S_L_C:    n = S_L_Z;
                S_L_Z:    n = S_L_T1;
                S_L_T1:   n = S_L_MLEN;
                S_L_MLEN: n = S_L_MSG;
                S_L_MSG:  n = S_L_H;
                S_L_H:    n = S_WAIT_RES;
                default:  n = S_IDLE;
            endcase
        end else begin
            case (s)
                S_L_RHO:  n = S_L_T1;
                S_L_T1:   n = S_L_C;
                S_L_C:    n = S_L_Z;
                S_L_Z:    n = S_L_H;
                S_L_H:    n = S_L_MLEN;
                S_L_MLEN: n = S_L_MSG;
                S_L_MSG:  n = S_WAIT_RES;
                default:  n = S_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic field_t state_field(input seq_state_t s);
        field_t f;
        case (s)
            S_L_C:    f = F_C;
            S_L_Z:    f = F_Z;
            S_L_T1:   f = F_T1;
            S_L_MLEN: f = F_MLEN;
            S_L_MSG:  f = F_MSG;
            S_L_H:    f = F_H;
            default:  f = F_RHO;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/verify_input_sequencer_fld_out_reg.sv
// One-entry valid/ready register carrying a tagged word to the verify core.
// Accepts a new word in the same cycle the held one drains, so a full stream has no bubbles.
module verify_input_sequencer_fld_out_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [2:0]   in_id_i,
    input  logic [15:0]  in_idx_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [2:0]   out_id_o,
    output logic [15:0]  out_idx_o,
    output logic [W-1:0] out_data_o,
    output logic         out_last_o
);

    logic         valid_q;
    logic [2:0]   id_q;
    logic [15:0]  idx_q;
    logic [W-1:0] data_q;
    logic         last_q;
    logic         load;

    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            id_q    <= in_id_i;
            idx_q   <= in_idx_i;
            data_q  <= in_data_i;
            last_q  <= in_last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_id_o    = id_q;
    assign out_idx_o   = idx_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/verify_input_sequencer.sv
// Receives the verify word stream, tags each word with field id and index for the core,
// and returns the single-word accept/reject result to the host.
module verify_input_sequencer
    import verify_input_sequencer_pkg::*;
#(
    parameter int W          = 64,
    parameter int HIGH_PERF  = 1,
    parameter int SEED_WORDS = SEED_WORDS_ALL,
    parameter int Z_WORDS    = Z_WORDS_L2,
    parameter int T1_WORDS   = T1_WORDS_L2,
    parameter int H_WORDS    = H_WORDS_L2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         valid_i,
    output logic         ready_i,
    input  logic [W-1:0] data_i,
    output logic         fld_valid_o,
    input  logic         fld_ready_i,
    output logic [2:0]   fld_id_o,
    output logic [15:0]  fld_idx_o,
    output logic [W-1:0] fld_data_o,
    output logic         fld_last_o,
    input  logic         res_valid_i,
    input  logic         res_i,
    output logic         valid_o,
    input  logic         ready_o,
    output logic [W-1:0] data_o,
    output logic         done
);

    localparam int   BYTES_PER_WORD = W / 8;
    localparam int   BPW_LOG2       = $clog2(BYTES_PER_WORD);
    localparam logic HP             = (HIGH_PERF != 0);

    seq_state_t  state_q, state_d;
    logic [28:0] cnt_q, cnt_d;
    logic [28:0] msg_words_q, msg_words_d;
    logic        drain_q, drain_d;
    logic        res_q, res_d;
    logic        valid_o_q, valid_o_d;
    logic        done_q, done_d;

    logic        is_load;
    logic        reg_in_ready;
    logic        reg_out_valid;
    logic        xfer;
    logic        word_last;
    logic        last_field;
    logic [28:0] field_len;
    logic [28:0] msg_words_calc;
    field_t      cur_field;

    // Once the final field is in the output register, stop taking words until it drains.
    assign is_load   = (state_q >= S_L_RHO) && (state_q <= S_L_H) && !drain_q;
    assign ready_i   = is_load && reg_in_ready;
    assign xfer      = valid_i && ready_i;
    assign cur_field = state_field(state_q);

    always_comb begin
        field_len = 29'd1;
        case (state_q)
            S_L_RHO, S_L_C: field_len = 29'(SEED_WORDS);
            S_L_Z:          field_len = 29'(Z_WORDS);
            S_L_T1:         field_len = 29'(T1_WORDS);
            S_L_H:          field_len = 29'(H_WORDS);
            S_L_MSG:        field_len = msg_words_q;
            default:        field_len = 29'd1;
        endcase
    end

    assign word_last  = (cnt_q == field_len - 29'd1);
    assign last_field = (next_load_state(state_q, HP) == S_WAIT_RES);

    // Message length in bytes rounded up to whole words; an empty message still sends one pad word.
    always_comb begin
        msg_words_calc = 29'(({1'b0, data_i[31:0]} + 33'(BYTES_PER_WORD - 1)) >> BPW_LOG2);
        if (msg_words_calc == 29'd0) begin
            msg_words_calc = 29'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        msg_words_d = msg_words_q;
        drain_d     = drain_q;
        res_d       = res_q;
        valid_o_d   = valid_o_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (mode == VERIFY_MODE)) begin
                    state_d = S_L_RHO;
                    cnt_d   = '0;
                    drain_d = 1'b0;
                end
            end
            S_WAIT_RES: begin
                if (res_valid_i) begin
                    res_d     = res_i;
                    valid_o_d = 1'b1;
                    state_d   = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (ready_o) begin
                    valid_o_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                if (xfer) begin
                    if (state_q == S_L_MLEN) begin
                        msg_words_d = msg_words_calc;
                    end
                    if (word_last) begin
                        cnt_d = '0;
                        if (last_field) begin
                            drain_d = 1'b1;
                        end else begin
                            state_d = next_load_state(state_q, HP);
                        end
                    end else begin
                        cnt_d = cnt_q + 29'd1;
                    end
                end
                if (drain_q && (!reg_out_valid || fld_ready_i)) begin
                    drain_d = 1'b0;
                    state_d = S_WAIT_RES;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            msg_words_q <= '0;
            drain_q     <= 1'b0;
            res_q       <= 1'b0;
            valid_o_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            msg_words_q <= msg_words_d;
            drain_q     <= drain_d;
            res_q       <= res_d;
            valid_o_q   <= valid_o_d;
            done_q      <= done_d;
        end
    end

    verify_input_sequencer_fld_out_reg #(
        .W(W)
    ) u_fld_out_reg (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (xfer),
        .in_ready_o (reg_in_ready),
        .in_id_i    (cur_field),
        .in_idx_i   (cnt_q[15:0]),
        .in_data_i  (data_i),
        .in_last_i  (word_last),
        .out_valid_o(reg_out_valid),
        .out_ready_i(fld_ready_i),
        .out_id_o   (fld_id_o),
        .out_idx_o  (fld_idx_o),
        .out_data_o (fld_data_o),
        .out_last_o (fld_last_o)
    );

    assign fld_valid_o = reg_out_valid;
    assign valid_o     = valid_o_q;
    assign data_o      = {{(W-1){1'b0}}, res_q};
    assign done        = done_q;

endmodule

// File: tb/tb_verify_input_sequencer.sv
// Randomized bench for verify_input_sequencer: both field orders, stalls, empty message,
// held-off result unload and a mid-stream reset, checked against a field-list model.
`timescale 1ns/1ps
module tb_verify_input_sequencer;
    import verify_input_sequencer_pkg::*;

    localparam int W      = 64;
    localparam int BUDGET = 6000;

    typedef struct {
        logic [2:0]  id;
        logic [15:0] idx;
        logic [63:0] data;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start_hp, start_lr, sel;
    logic [1:0]   mode;
    logic         valid_i, fld_ready_i, res_valid_i, res_i, ready_o;
    logic [W-1:0] data_i;

    logic         ready_hp, ready_lr, fv_hp, fv_lr, last_hp, last_lr;
    logic [2:0]   id_hp, id_lr;
    logic [15:0]  idx_hp, idx_lr;
    logic [W-1:0] fd_hp, fd_lr, do_hp, do_lr;
    logic         vo_hp, vo_lr, done_hp, done_lr;

    logic         ready_w, fv_w, last_w, vo_w, done_w;
    logic [2:0]   id_w;
    logic [15:0]  idx_w;
    logic [W-1:0] fd_w, do_w;

    assign ready_w = sel ? ready_hp : ready_lr;
    assign fv_w    = sel ? fv_hp    : fv_lr;
    assign last_w  = sel ? last_hp  : last_lr;
    assign id_w    = sel ? id_hp    : id_lr;
    assign idx_w   = sel ? idx_hp   : idx_lr;
    assign fd_w    = sel ? fd_hp    : fd_lr;
    assign vo_w    = sel ? vo_hp    : vo_lr;
    assign do_w    = sel ? do_hp    : do_lr;
    assign done_w  = sel ? done_hp  : done_lr;

    verify_input_sequencer #(.W(W), .HIGH_PERF(1)) u_dut_hp (
        .clk(clk), .rst(rst), .start(start_hp), .mode(mode),
        .valid_i(valid_i), .ready_i(ready_hp), .data_i(data_i),
        .fld_valid_o(fv_hp), .fld_ready_i(fld_ready_i), .fld_id_o(id_hp),
        .fld_idx_o(idx_hp), .fld_data_o(fd_hp), .fld_last_o(last_hp),
        .res_valid_i(res_valid_i), .res_i(res_i),
        .valid_o(vo_hp), .ready_o(ready_o), .data_o(do_hp), .done(done_hp)
    );

    verify_input_sequencer #(.W(W), .HIGH_PERF(0)) u_dut_lr (
        .clk(clk), .rst(rst), .start(start_lr), .mode(mode),
        .valid_i(valid_i), .ready_i(ready_lr), .data_i(data_i),
        .fld_valid_o(fv_lr), .fld_ready_i(fld_ready_i), .fld_id_o(id_lr),
        .fld_idx_o(idx_lr), .fld_data_o(fd_lr), .fld_last_o(last_lr),
        .res_valid_i(res_valid_i), .res_i(res_i),
        .valid_o(vo_lr), .ready_o(ready_o), .data_o(do_lr), .done(done_lr)
    );

    int    n_cmp = 0;
    int    n_mis = 0;
    int    txn_no = 0;
    logic [63:0] in_q[$];
    word_t       exp_q[$];

    task automatic tb_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected stream straight from the field list: order, lengths, and the mlen rule.
    task automatic build_model(input bit hp, input int mlen);
        field_t order[7];
        if (hp) order = '{F_RHO, F_C, F_Z, F_T1, F_MLEN, F_MSG, F_H};
        else    order = '{F_RHO, F_T1, F_C, F_Z, F_H, F_MLEN, F_MSG};
        in_q.delete();
        exp_q.delete();
        foreach (order[k]) begin
            int n;
            case (order[k])
                F_RHO, F_C: n = 4;
                F_Z:        n = 288;
                F_T1:       n = 160;
                F_H:        n = 11;
                F_MLEN:     n = 1;
                default:    n = (mlen == 0) ? 1 : (mlen + 7) / 8;
            endcase
            for (int i = 0; i < n; i++) begin
                logic [63:0] w;
                word_t e;
                w = {$urandom, $urandom};
                if (order[k] == F_MLEN) w[31:0] = mlen;
                in_q.push_back(w);
                e.id   = order[k];
                e.idx  = i[15:0];
                e.data = w;
                e.last = (i == n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tb_check({tag, "_ready_i"},   {63'd0, ready_w}, 64'd0);
        tb_check({tag, "_fld_valid"}, {63'd0, fv_w},    64'd0);
        tb_check({tag, "_fld_last"},  {63'd0, last_w},  64'd0);
        tb_check({tag, "_fld_id"},    {61'd0, id_w},    64'd0);
        tb_check({tag, "_fld_idx"},   {48'd0, idx_w},   64'd0);
        tb_check({tag, "_fld_data"},  fd_w,             64'd0);
        tb_check({tag, "_valid_o"},   {63'd0, vo_w},    64'd0);
        tb_check({tag, "_data_o"},    do_w,             64'd0);
        tb_check({tag, "_done"},      {63'd0, done_w},  64'd0);
    endtask

    // pol: 0 = full rate, 1 = fld_ready 1-0-1-0 with random valid, 2 = both random plus stray starts
    task automatic run_txn(input bit hp, input int mlen, input int pol, input bit res, input int abort_at);
        int cyc, first_cyc, last_cyc, n_out, n_last, accepted, total;
        bit aborted;
        word_t e;
        build_model(hp, mlen);
        total     = exp_q.size();
        cyc       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        n_out     = 0;
        n_last    = 0;
        accepted  = 0;
        aborted   = 1'b0;
        sel       = hp;
        @(negedge clk);
        mode = VERIFY_MODE;
        if (hp) start_hp = 1'b1; else start_lr = 1'b1;
        while (exp_q.size() > 0 && cyc < BUDGET && !aborted) begin
            @(negedge clk);
            start_hp = 1'b0;
            start_lr = 1'b0;
            if (pol == 2 && cyc > 0) begin
                if (hp) start_hp = 1'($urandom_range(0, 1)); else start_lr = 1'($urandom_range(0, 1));
            end
            case (pol)
                0:       fld_ready_i = 1'b1;
                1:       fld_ready_i = (cyc % 2 == 0);
                default: fld_ready_i = 1'($urandom_range(0, 1));
            endcase
            valid_i = (in_q.size() > 0) && ((pol == 0) || ($urandom_range(0, 1) == 1));
            data_i  = (in_q.size() > 0) ? in_q[0] : {$urandom, $urandom};
            #1;
            if (fv_w && !fld_ready_i) tb_check("no_overflow_ready_i", {63'd0, ready_w}, 64'd0);
            if (fv_w && fld_ready_i) begin
                e = exp_q.pop_front();
                tb_check("fld_tag", {44'd0, id_w, idx_w, last_w}, {44'd0, e.id, e.idx, e.last});
                tb_check("fld_data", fd_w, e.data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
                if (last_w) n_last++;
            end
            if (valid_i && ready_w && in_q.size() > 0) begin
                void'(in_q.pop_front());
                accepted++;
                if (accepted == abort_at) aborted = 1'b1;
            end
            cyc++;
        end

        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
            valid_i = 1'b0;
            start_hp = 1'b0;
            start_lr = 1'b0;
            @(negedge clk);
            #1;
            check_reset_outputs("midrst");
            rst = 1'b0;
            $display("txn %0d: hp=%0d mlen=%0d reset after %0d words accepted, %0d forwarded", txn_no, hp, mlen, accepted, n_out);
        end else if (exp_q.size() != 0) begin
            tb_check("stream_budget_left", exp_q.size(), 0);
            @(negedge clk);
            rst = 1'b1;
            valid_i = 1'b0;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            tb_check("word_count", n_out, total);
            tb_check("last_count", n_last, 7);
            if (pol == 0) tb_check("no_bubbles_span", last_cyc - first_cyc + 1, total);
            @(negedge clk);
            start_hp = 1'b0;
            start_lr = 1'b0;
            valid_i = 1'b0;
            fld_ready_i = 1'b1;
            res_valid_i = 1'b1;
            res_i = res;
            @(negedge clk);
            res_valid_i = 1'b0;
            res_i = ~res;
            #1;
            tb_check("res_valid_o", {63'd0, vo_w}, 64'd1);
            tb_check("res_data_o", do_w, {63'd0, res});
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                #1;
                tb_check("hold_valid_o", {63'd0, vo_w}, 64'd1);
                tb_check("hold_data_o", do_w, {63'd0, res});
                tb_check("hold_no_done", {63'd0, done_w}, 64'd0);
            end
            @(negedge clk);
            ready_o = 1'b1;
            #1;
            tb_check("done_before_hs", {63'd0, done_w}, 64'd0);
            @(negedge clk);
            ready_o = 1'b0;
            #1;
            tb_check("valid_o_after_hs", {63'd0, vo_w}, 64'd0);
            tb_check("done_pulse", {63'd0, done_w}, 64'd1);
            @(negedge clk);
            #1;
            tb_check("done_one_cycle", {63'd0, done_w}, 64'd0);
            $display("txn %0d: hp=%0d mlen=%0d words=%0d/%0d lasts=%0d result=%0d", txn_no, hp, mlen, n_out, total, n_last, res);
        end
        txn_no++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_hp = 1'b0; start_lr = 1'b0; sel = 1'b1;
        mode = VERIFY_MODE; valid_i = 1'b0; data_i = '0; fld_ready_i = 1'b1;
        res_valid_i = 1'b0; res_i = 1'b0; ready_o = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        // Start with a non-verify mode and a stray result in IDLE must both be ignored.
        @(negedge clk);
        mode = VERIFY_MODE ^ 2'd1;
        start_hp = 1'b1;
        res_valid_i = 1'b1;
        res_i = 1'b1;
        @(negedge clk);
        start_hp = 1'b0;
        res_valid_i = 1'b0;
        valid_i = 1'b1;
        #1;
        tb_check("badmode_ready_i", {63'd0, ready_w}, 64'd0);
        tb_check("idle_res_valid_o", {63'd0, vo_w}, 64'd0);
        @(negedge clk);
        #1;
        tb_check("badmode_ready_i_2", {63'd0, ready_w}, 64'd0);
        valid_i = 1'b0;

        run_txn(1'b1, 33, 0, 1'b0, -1);
        run_txn(1'b0, 64, 0, 1'b1, -1);
        run_txn(1'b0, 0, 2, 1'($urandom_range(0, 1)), -1);
        run_txn(1'b1, 0, 1, 1'b1, -1);
        run_txn(1'b1, $urandom_range(1, 200), 1, 1'b0, 109);
        run_txn(1'b1, $urandom_range(1, 200), 2, 1'b1, -1);
        run_txn(1'b0, $urandom_range(1, 200), 1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
